// File: rtl/ysyx_24100027_ifu_pkg.sv
// rtl/ysyx_24100027_ifu_pkg.sv - shared fetch-unit state encoding and constants
package ysyx_24100027_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24100027_ifu.sv
// rtl/ysyx_24100027_ifu.sv - single-outstanding instruction fetch unit with execute redirect
module ysyx_24100027_ifu
  import ysyx_24100027_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_t  state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] rd_pc;
  logic [31:0] pc_seq;
  logic        unused_rd_lsb;

  assign rd_pc         = {redirect_pc[31:2], 2'b00};
  assign pc_seq        = pc + PC_STEP;
  assign unused_rd_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IFU_REQ;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      inst_valid     <= 1'b0;
      inst           <= 32'h0;
      inst_pc        <= 32'h0;
      inst_err       <= 1'b0;
    end else begin
      case (state)
        IFU_REQ: begin
          imem_req_valid <= 1'b1;
          // The issued address is never retargeted; a redirect marks its response for dropping.
          if (redirect_valid) begin
            pc   <= rd_pc;
            kill <= 1'b1;
          end
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill || redirect_valid) begin
              kill           <= 1'b0;
              pc             <= redirect_valid ? rd_pc : pc;
              imem_req_addr  <= redirect_valid ? rd_pc : pc;
              imem_req_valid <= 1'b1;
              state          <= IFU_REQ;
            end else begin
              inst       <= imem_rsp_data;
              inst_err   <= imem_rsp_err;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= IFU_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= rd_pc;
            kill <= 1'b1;
          end
        end
        IFU_HOLD: begin
          // A redirect wins over the sequential step even when decode takes the word this cycle.
          if (redirect_valid || inst_ready) begin
            inst_valid     <= 1'b0;
            pc             <= redirect_valid ? rd_pc : pc_seq;
            imem_req_addr  <= redirect_valid ? rd_pc : pc_seq;
            imem_req_valid <= 1'b1;
            state          <= IFU_REQ;
          end
        end
        default: begin
          state          <= IFU_REQ;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (state == IFU_WAIT));

endmodule
